// File: rtl/mat_host_port_pkg.sv
// Shared types for the matrix core host port.
// Scalars travel as raw 32-bit single-precision bit patterns.
package mat_host_port_pkg;

    typedef logic [31:0] mat_scalar_t;

    typedef enum logic [1:0] {
        MAT_DM_WRITE_NONE = 2'd0,
        MAT_DM_WRITE_ROW  = 2'd1,
        MAT_DM_WRITE_ELEM = 2'd2
    } MatDataMemWriteOp_t;

    typedef enum logic [2:0] {
        MAT_HP_IDLE   = 3'd0,
        MAT_HP_LOAD   = 3'd1,
        MAT_HP_RUN    = 3'd2,
        MAT_HP_DRAIN  = 3'd3,
        MAT_HP_FINISH = 3'd4
    } MatHostPortState_t;

    localparam int MAT_HOST_PORT_CTRL_RESET_CYCLES = 1;
    localparam int MAT_HOST_PORT_RST_CW =
        $clog2(MAT_HOST_PORT_CTRL_RESET_CYCLES + 1);

endpackage

// File: rtl/mat_host_port_if.sv
// Host stream, control and data-memory signals of the host port.
// slave is the port itself; master is the surrounding system.
interface mat_host_port_if
    import mat_host_port_pkg::*;
#(
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32
) ();

    logic                          start;
    logic [DATA_MEM_ADDR_SIZE-1:0] load_rows;
    logic [DATA_MEM_ADDR_SIZE-1:0] drain_rows;

    logic                          in_valid;
    logic                          in_ready;
    mat_scalar_t                   in_data;

    logic                          out_valid;
    logic                          out_ready;
    mat_scalar_t                   out_data;
    logic                          out_last;

    logic                          ctrl_reset;
    logic                          ctrl_done;

    logic [DATA_MEM_ADDR_SIZE-1:0] data_mem_read_addr;
    mat_scalar_t [WIDTH-1:0]       data_mem_data_out;
    MatDataMemWriteOp_t            data_mem_write_op;
    logic [DATA_MEM_ADDR_SIZE-1:0] data_mem_write_addr;
    mat_scalar_t [WIDTH-1:0]       data_mem_data_in;

    logic                          busy;
    logic                          finished;

    modport slave (
        input  start, load_rows, drain_rows,
        input  in_valid, in_data, out_ready,
        input  ctrl_done, data_mem_data_out,
        output in_ready, out_valid, out_data, out_last,
        output ctrl_reset, data_mem_read_addr,
        output data_mem_write_op, data_mem_write_addr,
        output data_mem_data_in, busy, finished
    );

    modport master (
        output start, load_rows, drain_rows,
        output in_valid, in_data, out_ready,
        output ctrl_done, data_mem_data_out,
        input  in_ready, out_valid, out_data, out_last,
        input  ctrl_reset, data_mem_read_addr,
        input  data_mem_write_op, data_mem_write_addr,
        input  data_mem_data_in, busy, finished
    );

endinterface

// File: rtl/mat_host_port_packer.sv
// Row packer: gathers WIDTH scalars into one data-memory row.
// The last scalar is passed through live so the row write lands on its beat.
module mat_host_port_packer
    import mat_host_port_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_beat,
    input  mat_scalar_t             i_data,
    output logic                    o_row_done,
    output mat_scalar_t [WIDTH-1:0] o_row
);

    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

    logic [CW-1:0]           r_col;
    mat_scalar_t [WIDTH-2:0] r_buf;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_col <= '0;
            r_buf <= '0;
        end else begin
            if (i_clear)
                r_col <= '0;
            else if (i_beat)
                r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (i_beat && r_col == CW'(i))
                    r_buf[i] <= i_data;
            end
        end
    end

    assign o_row_done = i_beat && (r_col == LAST_COL);
    assign o_row      = {i_data, r_buf};

endmodule

// File: rtl/mat_host_port.sv
// Host streaming port for the matrix core: load rows, run MatControl,
// then drain rows back out as a scalar stream.
module mat_host_port
    import mat_host_port_pkg::*;
#(
    parameter int WIDTH              = 16,
    parameter int DATA_MEM_ADDR_SIZE = 32,
    parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    mat_host_port_if.slave bus
);

    localparam int AW  = DATA_MEM_ADDR_SIZE;
    localparam int CW  = WIDTH_ADDR_SIZE;
    localparam int RCW = MAT_HOST_PORT_RST_CW;
    localparam logic [CW-1:0]  LAST_COL = CW'(WIDTH - 1);
    localparam logic [RCW-1:0] RST_CYC  =
        RCW'(MAT_HOST_PORT_CTRL_RESET_CYCLES);

    MatHostPortState_t       r_state;
    MatHostPortState_t       w_state_nx;
    logic [AW-1:0]           r_row;
    logic [AW-1:0]           r_load_rows;
    logic [AW-1:0]           r_drain_rows;
    logic [CW-1:0]           r_col;
    logic [RCW-1:0]          r_rst_cnt;
    logic                    w_load_act;
    logic                    w_beat;
    logic                    w_fire;
    logic                    w_last;
    logic                    w_armed;
    logic                    w_enter;
    logic                    w_row_done;
    mat_scalar_t [WIDTH-1:0] w_row_data;

    // Reset also blocks acceptance so an aborted row never reaches memory
    assign w_load_act = (r_state == MAT_HP_LOAD) && !reset;
    assign w_beat     = bus.in_valid && w_load_act;
    assign w_fire     = (r_state == MAT_HP_DRAIN) && bus.out_ready;
    assign w_last     = (r_state == MAT_HP_DRAIN) &&
                        (r_col == LAST_COL) &&
                        (r_row == r_drain_rows - 1'b1);
    assign w_armed    = (r_rst_cnt == RST_CYC);
    assign w_enter    = (w_state_nx != r_state);

    mat_host_port_packer #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .i_clear    (w_enter),
        .i_beat     (w_beat),
        .i_data     (bus.in_data),
        .o_row_done (w_row_done),
        .o_row      (w_row_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= MAT_HP_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_rst_cnt    <= '0;
            r_load_rows  <= '0;
            r_drain_rows <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == MAT_HP_IDLE && bus.start) begin
                r_load_rows  <= bus.load_rows;
                r_drain_rows <= bus.drain_rows;
            end
            if (w_enter) begin
                r_row     <= '0;
                r_col     <= '0;
                r_rst_cnt <= '0;
            end else begin
                if (w_row_done)
                    r_row <= r_row + 1'b1;
                if (w_fire) begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                if (r_state == MAT_HP_RUN && !w_armed)
                    r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nx            = r_state;
        bus.in_ready          = w_load_act;
        bus.out_valid         = 1'b0;
        bus.out_last          = 1'b0;
        bus.ctrl_reset        = 1'b1;
        bus.busy              = 1'b1;
        bus.finished          = 1'b0;
        bus.data_mem_write_op = w_row_done ? MAT_DM_WRITE_ROW
                                           : MAT_DM_WRITE_NONE;
        unique case (r_state)
            MAT_HP_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start)
                    w_state_nx = (bus.load_rows == '0) ? MAT_HP_RUN
                                                       : MAT_HP_LOAD;
            end
            MAT_HP_LOAD: begin
                if (w_row_done && r_row == r_load_rows - 1'b1)
                    w_state_nx = MAT_HP_RUN;
            end
            MAT_HP_RUN: begin
                // A stale done is ignored until the forced reset has elapsed
                bus.ctrl_reset = !w_armed;
                if (w_armed && bus.ctrl_done)
                    w_state_nx = (r_drain_rows == '0) ? MAT_HP_FINISH
                                                      : MAT_HP_DRAIN;
            end
            MAT_HP_DRAIN: begin
                bus.ctrl_reset = 1'b0;
                bus.out_valid  = 1'b1;
                bus.out_last   = w_last;
                if (w_fire && w_last)
                    w_state_nx = MAT_HP_FINISH;
            end
            MAT_HP_FINISH: begin
                bus.finished = 1'b1;
                w_state_nx   = MAT_HP_IDLE;
            end
            default: begin
                w_state_nx = MAT_HP_IDLE;
            end
        endcase
    end

    assign bus.data_mem_read_addr  = r_row;
    assign bus.data_mem_write_addr = r_row;
    assign bus.data_mem_data_in    = w_row_data;
    assign bus.out_data            = bus.data_mem_data_out[r_col];

endmodule

// File: tb/tb_mat_host_port.sv
// Scoreboard bench for mat_host_port with a behavioural data memory,
// a MatControl stand-in and a queue-based reference of the host traffic.
module tb_mat_host_port;
    import mat_host_port_pkg::*;

    localparam int W  = 4;
    localparam int AW = 32;
    localparam int NR = 16;

    typedef logic [W-1:0][31:0] row_t;
    typedef struct {
        logic [AW-1:0] addr;
        row_t          data;
    } wr_t;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_host_port_if #(.WIDTH(W), .DATA_MEM_ADDR_SIZE(AW)) bus ();

    mat_host_port #(
        .WIDTH              (W),
        .DATA_MEM_ADDR_SIZE (AW)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Data memory stand-in: row write on the clock, combinational read
    row_t mem [NR];
    always @(posedge clk)
        if (bus.data_mem_write_op == MAT_DM_WRITE_ROW)
            mem[bus.data_mem_write_addr[3:0]] <= bus.data_mem_data_in;
    assign bus.data_mem_data_out = mem[bus.data_mem_read_addr[3:0]];

    row_t ref_mem [NR];
    wr_t  exp_wr[$];
    out_t exp_out[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int fin_seen = 0;
    int wr_cnt   = 0;
    int rdy_mode = 0;
    int done_dly = 2;
    bit done_tied = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fbits(input int k);
        logic [31:0] t [8] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000,
                               32'h40E00000, 32'h41000000};
        return t[k % 8];
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = ($urandom_range(1) == 1);
            endcase
        end
    end

    // MatControl stand-in: done some cycles after its reset is released
    initial begin : ctrl_model
        int cnt;
        cnt = 0;
        bus.ctrl_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (done_tied) begin
                bus.ctrl_done = 1'b1;
            end else if (bus.ctrl_reset) begin
                cnt = 0;
                bus.ctrl_done = 1'b0;
            end else begin
                cnt++;
                bus.ctrl_done = (cnt >= done_dly);
            end
        end
    end

    initial begin : monitor
        wr_t  w;
        out_t o;
        forever begin
            @(negedge clk);
            if (bus.data_mem_write_op == MAT_DM_WRITE_ROW) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h",
                             bus.data_mem_write_addr);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.data_mem_write_addr, w.addr);
                    chk("wr_data", bus.data_mem_data_in, w.data);
                end
            end
            if (bus.out_valid) begin
                chk("in_ready_off", bus.in_ready, 0);
                if (exp_out.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: data %0h",
                             bus.out_data);
                end else begin
                    o = exp_out[0];
                    if (bus.out_ready) begin
                        void'(exp_out.pop_front());
                        chk("out_data", bus.out_data, o.data);
                        chk("out_last", bus.out_last, o.last);
                    end else begin
                        chk("stall_data", bus.out_data, o.data);
                        chk("stall_last", bus.out_last, o.last);
                    end
                end
            end
            if (bus.finished) fin_seen++;
        end
    end

    // Beats are presented with random gaps; stray start pulses must be ignored
    task automatic load_stream(input logic [31:0] d[$], input int n,
                               input int gap);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 400) begin
            bus.in_valid   = ($urandom_range(99) >= gap);
            bus.in_data    = bus.in_valid ? d[i] : $urandom();
            bus.start      = ($urandom_range(3) == 0);
            bus.load_rows  = AW'($urandom_range(7));
            bus.drain_rows = AW'($urandom_range(7));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        chk("load_beats", i, n);
    endtask

    task automatic run_job(input int lr, input int dr, input int gap,
                           input int rmode, input bit rnd);
        logic [31:0] d[$];
        int f0;
        rdy_mode = rmode;
        done_dly = $urandom_range(1, 5);
        for (int k = 0; k < lr * W; k++)
            d.push_back(rnd ? $urandom() : fbits(k));
        for (int r = 0; r < lr; r++) begin
            row_t row;
            for (int c = 0; c < W; c++) row[c] = d[r * W + c];
            ref_mem[r] = row;
            exp_wr.push_back('{addr: AW'(r), data: row});
        end
        for (int r = 0; r < dr; r++)
            for (int c = 0; c < W; c++)
                exp_out.push_back('{data: ref_mem[r][c],
                                    last: (r == dr - 1 && c == W - 1)});
        f0 = fin_seen;
        bus.load_rows  = AW'(lr);
        bus.drain_rows = AW'(dr);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (lr > 0) load_stream(d, lr * W, gap);
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom();
        for (int t = 0; t < 600 && fin_seen == f0; t++) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("finished_pulses", fin_seen - f0, 1);
        @(negedge clk);
        chk("busy_after", bus.busy, 0);
        chk("finished_once", bus.finished, 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] d5[$];
        int w0;
        bus.start      = 1'b0;
        bus.load_rows  = '0;
        bus.drain_rows = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_finished", bus.finished, 0);
        chk("rst_ctrl_reset", bus.ctrl_reset, 1);
        chk("rst_write_op", bus.data_mem_write_op, MAT_DM_WRITE_NONE);
        chk("rst_rd_addr", bus.data_mem_read_addr, 0);
        chk("rst_wr_addr", bus.data_mem_write_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back load of 1.0..8.0, then drain with ready held
        run_job(2, 2, 0, 0, 1'b0);
        // Drain only, out_ready toggling every cycle
        run_job(0, 2, 0, 1, 1'b0);
        // Same contents loaded with random gaps
        run_job(2, 0, 40, 0, 1'b0);

        // Empty job with ctrl_done stuck high
        done_tied = 1'b1;
        @(posedge clk); #1;
        w0 = wr_cnt;
        bus.load_rows  = '0;
        bus.drain_rows = '0;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4_busy_run", bus.busy, 1);
        chk("t4_rst_first", bus.ctrl_reset, 1);
        chk("t4_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("t4_rst_second", bus.ctrl_reset, 0);
        chk("t4_no_fin_yet", bus.finished, 0);
        @(negedge clk);
        chk("t4_finished", bus.finished, 1);
        chk("t4_rst_finish", bus.ctrl_reset, 1);
        @(negedge clk);
        chk("t4_idle", bus.busy, 0);
        chk("t4_no_writes", wr_cnt - w0, 0);
        done_tied = 1'b0;
        @(posedge clk); #1;

        // Reset after six of eight load beats
        for (int k = 0; k < 2 * W; k++) d5.push_back($urandom());
        for (int c = 0; c < W; c++) ref_mem[0][c] = d5[c];
        exp_wr.push_back('{addr: '0, data: ref_mem[0]});
        bus.load_rows  = AW'(2);
        bus.drain_rows = AW'(1);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        load_stream(d5, 6, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = d5[6];
        rst = 1'b1;
        @(negedge clk);
        chk("t5_no_write", bus.data_mem_write_op, MAT_DM_WRITE_NONE);
        chk("t5_not_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_idle", bus.busy, 0);
        chk("t5_ctrl_reset", bus.ctrl_reset, 1);
        chk("t5_row1_kept", mem[1], ref_mem[1]);
        @(posedge clk); #1;
        run_job(2, 2, 20, 0, 1'b1);

        for (int j = 0; j < 5; j++) begin
            int lr;
            int dr;
            lr = $urandom_range(1, 4);
            dr = $urandom_range(0, lr);
            run_job(lr, dr, $urandom_range(0, 50), 2, 1'b1);
        end

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("out_queue_empty", exp_out.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_host_port.md
# mat_host_port

Host-side streaming port for the matrix core. It sits between an external host stream and the `MatDataMem`/`MatControl` pair, and it runs three phases in sequence:
- **Load:** packs incoming scalars into data-memory rows.
- **Run:** releases `MatControl` from reset and waits for its `done`.
- **Drain:** reads data-memory rows back out as a scalar stream.

It replaces file-based memory preload and dump with a cycle-accurate handshake path.

## Interface
- `WIDTH`, 16, scalars per data-memory row.
- `DATA_MEM_ADDR_SIZE`, 32, data-memory row address width.
- `WIDTH_ADDR_SIZE`, `$clog2(WIDTH)`, column counter width (derived).

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; accepted only in IDLE.
- `load_rows`  in  DATA_MEM_ADDR_SIZE  rows to load, latched on accepted `start`.
- `drain_rows`  in  DATA_MEM_ADDR_SIZE  rows to drain, latched on accepted `start`.
- `in_valid` in 1, `in_ready` out 1, `in_data` in shortreal  load stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out shortreal, `out_last` out 1  drain stream.
- `ctrl_reset`  out  1  reset to `MatControl`.
- `ctrl_done`  in  1  `done` from `MatControl`.
- `data_mem_read_addr`  out  DATA_MEM_ADDR_SIZE  row read address.
- `data_mem_data_out`  in  shortreal[WIDTH]  row read data, combinational.
- `data_mem_write_op`  out  MatDataMemWriteOp_t  write command.
- `data_mem_write_addr`  out  DATA_MEM_ADDR_SIZE  write row.
- `data_mem_data_in`  out  shortreal[WIDTH]  write row data.
- `busy`  out  1  high in any state except IDLE.
- `finished`  out  1  one-cycle pulse at end of drain.

## Operation
States and transitions:
- **IDLE**
  - `start` moves to LOAD. If latched `load_rows`==0, it moves directly to RUN instead.
- **LOAD**
  - `in_ready`=1.
  - Each accepted beat (`in_valid`&&`in_ready`) stores `in_data` into row buffer slot `col`, then `col`++.
  - Element 0 of a row is the first beat.
  - On the beat with `col`==WIDTH-1, in that same cycle:
    - `data_mem_write_op` = full-row write encoding;
    - `data_mem_write_addr` = `row`;
    - `data_mem_data_in` = buffer slots 0..WIDTH-2 plus live `in_data` in slot WIDTH-1.
  - Then `col`←0 and `row`++.
  - After the write of row `load_rows`-1, go to RUN.
- **RUN**
  - `ctrl_reset`=1 in the first RUN cycle, 0 afterwards.
  - On `ctrl_done`=1 sampled after that first cycle, go to DRAIN, or to FINISH if `drain_rows`==0.
- **DRAIN**
  - `data_mem_read_addr`=`row`, `out_data`=`data_mem_data_out[col]`, `out_valid`=1.
  - On `out_valid`&&`out_ready`, `col`++. At WIDTH-1, `col`←0 and `row`++.
  - `out_last`=1 only on element WIDTH-1 of row `drain_rows`-1. Its handshake moves to FINISH.
- **FINISH**
  - `finished`=1 for one cycle, then IDLE.

Other behaviour:
- `ctrl_reset`=1 in IDLE, LOAD and FINISH. `MatControl` is held in reset except during RUN and DRAIN.
- `data_mem_write_op` is the no-write encoding in all cycles except the row-completing LOAD beat.
- `row` and `col` are cleared on every state entry.
- Rows wrap modulo 2^DATA_MEM_ADDR_SIZE; no range check against memory size.

Boundary conditions:
- `start` outside IDLE is ignored; the latched counts are unchanged.
- `in_valid` while not in LOAD: the beat is not accepted (`in_ready`=0) and is not stored.
- `out_valid` is 0 outside DRAIN. `out_data` is don't-care when `out_valid`=0.
- A DRAIN beat with `out_ready`=0 holds `out_data`/`out_last` stable; `row`/`col` do not advance.
- `ctrl_done` that stays high from a prior run is masked by the forced reset cycle at RUN entry.
- `reset` at any point returns to IDLE on the next edge. An in-progress row is discarded and no memory write occurs in that cycle.

## Timing
- Reset values:
  - state IDLE, `row`=`col`=0;
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `busy`=0, `finished`=0;
  - `ctrl_reset`=1, `data_mem_write_op`=no-write;
  - addresses and row buffer 0.
- LOAD throughput: 1 scalar/cycle, zero-bubble. The row write lands on the same edge as its last beat.
- LOAD→RUN transition happens on that final write edge.
- DRAIN throughput: 1 scalar/cycle with `out_ready` held high. The first `out_valid` appears the cycle after DRAIN entry.
- RUN→DRAIN: 1 cycle after `ctrl_done` is sampled high.

## Structure
- The full-row and no-write encodings come from the existing `MatDataMemWriteOp_t` in the shared mat package.
- Add to that package:
  - `MatHostPortState_t` enum (IDLE, LOAD, RUN, DRAIN, FINISH);
  - a `MAT_HOST_PORT_CTRL_RESET_CYCLES = 1` constant.
- One natural sub-module: `MatRowPacker`, holding the row buffer, column counter and row-complete strobe used by LOAD.
- DRAIN indexing stays inline.

## Test plan
All scenarios use WIDTH=4.
1. `load_rows`=2, 8 back-to-back beats 1.0..8.0 → rows 0/1 hold {1,2,3,4}/{5,6,7,8}. Exactly two write cycles, on beats 4 and 8.
2. Random `in_valid` gaps during LOAD → same memory contents. No write on idle cycles.
3. `drain_rows`=2 with `out_ready` toggling 1,0,1,0 → out sequence 1..8 with no duplicates or drops. `out_last` only on 8.0. `finished` pulses once, then `busy`=0.
4. `load_rows`=0, `drain_rows`=0, `ctrl_done` tied high → IDLE→RUN. `ctrl_reset` high for exactly 1 RUN cycle, then FINISH; no memory writes.
5. `reset` asserted after 6 of 8 load beats → IDLE next edge, `ctrl_reset`=1. Row 1 is not written; a subsequent full load succeeds.
6. End-to-end with real `MatControl`/`MatDataMem` → drained stream matches the golden output of the current file-dump flow.
